// File: rtl/pipe_hazard_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared definitions for the pipeline stall/flush scheduler:
//                FSM state encoding and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int DEFAULT_CNT_W  = 32;
    localparam int DEFAULT_REG_AW = 5;

    // Encoding is visible on state_o, so the values are fixed explicitly.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_MEMWAIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_sched_if
//  Description : Bundle between the pipeline datapath and the stall/flush
//                scheduler.
//                master : datapath side (drives hazard/status inputs)
//                slave  : scheduler side (drives control + counters + state)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_sched_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int REG_AW = DEFAULT_REG_AW
);
    logic              start_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic [REG_AW-1:0] ex_rd_i;
    logic              ex_memrd_i;
    logic              mem_pcsrc_i;
    logic              dmem_busy_i;

    logic              pc_we_o;
    logic              if_id_we_o;
    logic              if_id_flush_o;
    logic              id_ex_bubble_o;
    logic              ex_mem_flush_o;
    logic              pipe_freeze_o;
    logic              stall_o;
    logic              flush_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;
    logic [CNT_W-1:0]  freeze_cnt_o;
    logic [1:0]        state_o;

    modport master (
        output start_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_i, ex_memrd_i, mem_pcsrc_i, dmem_busy_i,
        input  pc_we_o, if_id_we_o, if_id_flush_o, id_ex_bubble_o,
               ex_mem_flush_o, pipe_freeze_o, stall_o, flush_o,
               stall_cnt_o, flush_cnt_o, freeze_cnt_o, state_o
    );

    modport slave (
        input  start_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_i, ex_memrd_i, mem_pcsrc_i, dmem_busy_i,
        output pc_we_o, if_id_we_o, if_id_flush_o, id_ex_bubble_o,
               ex_mem_flush_o, pipe_freeze_o, stall_o, flush_o,
               stall_cnt_o, flush_cnt_o, freeze_cnt_o, state_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_sched_load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use hazard compare between the load in
//                ID/EX and the source registers of the instruction in IF/ID.
//  Ports       : id_rs1_i/id_rs2_i + use flags (ID sources), ex_rd_i and
//                ex_memrd_i (load in EX), hazard_o (stall required).
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  wire logic [REG_AW-1:0] id_rs1_i,
    input  wire logic [REG_AW-1:0] id_rs2_i,
    input  wire logic              id_use_rs1_i,
    input  wire logic              id_use_rs2_i,
    input  wire logic [REG_AW-1:0] ex_rd_i,
    input  wire logic              ex_memrd_i,
    output logic                   hazard_o
);
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = id_use_rs1_i && (ex_rd_i == id_rs1_i);
    assign w_rs2_hit = id_use_rs2_i && (ex_rd_i == id_rs2_i);

    // x0 is hard-wired zero, so a load targeting it never produces a value.
    assign hazard_o = ex_memrd_i && (ex_rd_i != '0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_sched
//  Description : Central stall/flush scheduler for the 5-stage pipeline.
//                Per-cycle priority: memory freeze > branch flush >
//                load-use stall > normal advance. Keeps saturating
//                stall / flush / freeze event counters.
//  Ports       : clk_i, rst_i (sync, active high), bus (slave modport:
//                hazard/status inputs, pipeline controls, counters, state).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_sched
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    pipe_hazard_sched_if.slave bus
);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_hazard;
    logic             w_inc_stall;
    logic             w_inc_flush;
    logic             w_inc_freeze;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    logic w_pc_we, w_if_id_we, w_if_id_flush, w_id_ex_bubble;
    logic w_ex_mem_flush, w_pipe_freeze, w_stall, w_flush;

    load_use_detect #(.REG_AW(REG_AW)) u_lud (
        .id_rs1_i     (bus.id_rs1_i),
        .id_rs2_i     (bus.id_rs2_i),
        .id_use_rs1_i (bus.id_use_rs1_i),
        .id_use_rs2_i (bus.id_use_rs2_i),
        .ex_rd_i      (bus.ex_rd_i),
        .ex_memrd_i   (bus.ex_memrd_i),
        .hazard_o     (w_hazard)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Defaults describe the idle/frozen pipeline; only an active, enabled
    // cycle releases the pipeline registers.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_we        = 1'b0;
        w_if_id_we     = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_pipe_freeze  = 1'b1;
        w_stall        = 1'b0;
        w_flush        = 1'b0;
        w_inc_stall    = 1'b0;
        w_inc_flush    = 1'b0;
        w_inc_freeze   = 1'b0;

        if (rst_i) begin
            w_state_nxt = S_IDLE;
        end else if (!bus.start_i) begin
            // Disabling the core leaves the pipeline frozen as-is.
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_RUN;
                end
                S_RUN, S_MEMWAIT: begin
                    if (bus.dmem_busy_i) begin
                        // A taken branch in EX/MEM is held here and flushed
                        // on the first cycle memory is ready again.
                        w_state_nxt  = S_MEMWAIT;
                        w_inc_freeze = 1'b1;
                    end else begin
                        w_state_nxt   = S_RUN;
                        w_pipe_freeze = 1'b0;
                        if (bus.mem_pcsrc_i) begin
                            // Redirect squashes the load-use victim too.
                            w_pc_we        = 1'b1;
                            w_if_id_we     = 1'b1;
                            w_if_id_flush  = 1'b1;
                            w_id_ex_bubble = 1'b1;
                            w_ex_mem_flush = 1'b1;
                            w_flush        = 1'b1;
                            w_inc_flush    = 1'b1;
                        end else if (w_hazard) begin
                            w_id_ex_bubble = 1'b1;
                            w_stall        = 1'b1;
                            w_inc_stall    = 1'b1;
                        end else begin
                            w_pc_we    = 1'b1;
                            w_if_id_we = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (w_inc_stall && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            end
            if (w_inc_flush && (r_flush_cnt != C_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
            end
            if (w_inc_freeze && (r_freeze_cnt != C_CNT_MAX)) begin
                r_freeze_cnt <= r_freeze_cnt + C_CNT_ONE;
            end
        end
    end

    assign bus.pc_we_o        = w_pc_we;
    assign bus.if_id_we_o     = w_if_id_we;
    assign bus.if_id_flush_o  = w_if_id_flush;
    assign bus.id_ex_bubble_o = w_id_ex_bubble;
    assign bus.ex_mem_flush_o = w_ex_mem_flush;
    assign bus.pipe_freeze_o  = w_pipe_freeze;
    assign bus.stall_o        = w_stall;
    assign bus.flush_o        = w_flush;
    assign bus.stall_cnt_o    = r_stall_cnt;
    assign bus.flush_cnt_o    = r_flush_cnt;
    assign bus.freeze_cnt_o   = r_freeze_cnt;
    assign bus.state_o        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_sched
//  Description : Self-checking bench for pipe_hazard_sched. Two instances
//                share stimulus: a 32-bit-counter one and a 4-bit-counter
//                one for saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_sched;
    import pipe_ctrl_pkg::*;

    // Control vector bit order:
    // {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_flush, freeze, stall, flush}
    localparam logic [7:0] C_IDLE   = 8'b0000_0100;
    localparam logic [7:0] C_FREEZE = 8'b0000_0100;
    localparam logic [7:0] C_NORM   = 8'b1100_0000;
    localparam logic [7:0] C_STALL  = 8'b0001_0010;
    localparam logic [7:0] C_FLUSH  = 8'b1111_1001;

    typedef struct {
        string      name;
        logic       rst;
        logic       start;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       memrd;
        logic       pcsrc;
        logic       busy;
        logic [7:0] exp_ctl;
        logic [1:0] exp_state;
        logic [2:0] exp_inc;   // {stall, flush, freeze}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, memrd, pcsrc, busy;

    int         n_tests  = 0;
    int         n_failed = 0;
    longint     exp_stall  = 0;
    longint     exp_flush  = 0;
    longint     exp_freeze = 0;
    longint     exp_stall4 = 0;

    vec_t       tbl[$];
    vec_t       sb[$];

    always #5 clk = ~clk;

    pipe_hazard_sched_if #(.CNT_W(32), .REG_AW(5)) bus32 ();
    pipe_hazard_sched_if #(.CNT_W(4),  .REG_AW(5)) bus4 ();

    assign bus32.start_i      = start;
    assign bus32.id_rs1_i     = rs1;
    assign bus32.id_rs2_i     = rs2;
    assign bus32.id_use_rs1_i = use1;
    assign bus32.id_use_rs2_i = use2;
    assign bus32.ex_rd_i      = rd;
    assign bus32.ex_memrd_i   = memrd;
    assign bus32.mem_pcsrc_i  = pcsrc;
    assign bus32.dmem_busy_i  = busy;

    assign bus4.start_i       = start;
    assign bus4.id_rs1_i      = rs1;
    assign bus4.id_rs2_i      = rs2;
    assign bus4.id_use_rs1_i  = use1;
    assign bus4.id_use_rs2_i  = use2;
    assign bus4.ex_rd_i       = rd;
    assign bus4.ex_memrd_i    = memrd;
    assign bus4.mem_pcsrc_i   = pcsrc;
    assign bus4.dmem_busy_i   = busy;

    pipe_hazard_sched #(.CNT_W(32), .REG_AW(5)) dut32 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus32.slave)
    );

    pipe_hazard_sched #(.CNT_W(4), .REG_AW(5)) dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4.slave)
    );

    function automatic vec_t mk(input string nm, input logic r, input logic s,
                                input logic [4:0] a1, input logic [4:0] a2,
                                input logic u1, input logic u2, input logic [4:0] d,
                                input logic mr, input logic pc, input logic bz,
                                input logic [7:0] ctl, input state_t st,
                                input logic [2:0] inc);
        vec_t v;
        v.name = nm; v.rst = r; v.start = s; v.rs1 = a1; v.rs2 = a2;
        v.use1 = u1; v.use2 = u2; v.rd = d; v.memrd = mr; v.pcsrc = pc;
        v.busy = bz; v.exp_ctl = ctl; v.exp_state = st; v.exp_inc = inc;
        return v;
    endfunction

    task automatic check(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Called just after a rising edge: drives one cycle, checks controls at
    // the falling edge and registered state/counters after the next edge.
    task automatic apply(input vec_t v);
        vec_t       e;
        logic [7:0] got_ctl;
        rst = v.rst; start = v.start; rs1 = v.rs1; rs2 = v.rs2;
        use1 = v.use1; use2 = v.use2; rd = v.rd; memrd = v.memrd;
        pcsrc = v.pcsrc; busy = v.busy;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        got_ctl = {bus32.pc_we_o, bus32.if_id_we_o, bus32.if_id_flush_o,
                   bus32.id_ex_bubble_o, bus32.ex_mem_flush_o,
                   bus32.pipe_freeze_o, bus32.stall_o, bus32.flush_o};
        check({e.name, ".ctl"}, longint'(got_ctl), longint'(e.exp_ctl));
        @(posedge clk);
        #1;
        if (e.rst) begin
            exp_stall = 0; exp_flush = 0; exp_freeze = 0; exp_stall4 = 0;
        end else begin
            exp_stall  += longint'(e.exp_inc[2]);
            exp_flush  += longint'(e.exp_inc[1]);
            exp_freeze += longint'(e.exp_inc[0]);
            if (e.exp_inc[2] && exp_stall4 < 15) exp_stall4++;
        end
        check({e.name, ".state"},  longint'(bus32.state_o), longint'(e.exp_state));
        check({e.name, ".stall"},  longint'(bus32.stall_cnt_o), exp_stall);
        check({e.name, ".flush"},  longint'(bus32.flush_cnt_o), exp_flush);
        check({e.name, ".freeze"}, longint'(bus32.freeze_cnt_o), exp_freeze);
        check({e.name, ".stall4"}, longint'(bus4.stall_cnt_o), exp_stall4);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        use1 = 1'b0; use2 = 1'b0; memrd = 1'b0; pcsrc = 1'b0; busy = 1'b0;

        //             name        rst st rs1   rs2   u1 u2 rd    mr pc bz ctl       next       inc
        tbl.push_back(mk("reset",   1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_IDLE,   S_IDLE,    3'b000));
        tbl.push_back(mk("rst_st",  1, 1, 5'd5, 5'd7, 1, 1, 5'd5, 1, 1, 1, C_IDLE,   S_IDLE,    3'b000));
        tbl.push_back(mk("idle_go", 0, 1, 5'd5, 5'd7, 1, 1, 5'd5, 1, 0, 0, C_IDLE,   S_RUN,     3'b000));
        tbl.push_back(mk("lu_add",  0, 1, 5'd5, 5'd7, 1, 1, 5'd5, 1, 0, 0, C_STALL,  S_RUN,     3'b100));
        tbl.push_back(mk("norm",    0, 1, 5'd5, 5'd7, 1, 1, 5'd5, 0, 0, 0, C_NORM,   S_RUN,     3'b000));
        tbl.push_back(mk("ld_x0",   0, 1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, C_NORM,   S_RUN,     3'b000));
        tbl.push_back(mk("lu_sw",   0, 1, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 0, C_STALL,  S_RUN,     3'b100));
        tbl.push_back(mk("lu_rs2",  0, 1, 5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, C_STALL,  S_RUN,     3'b100));
        tbl.push_back(mk("rs2_nou", 0, 1, 5'd1, 5'd5, 1, 0, 5'd5, 1, 0, 0, C_NORM,   S_RUN,     3'b000));
        tbl.push_back(mk("fl_lu",   0, 1, 5'd5, 5'd7, 1, 1, 5'd5, 1, 1, 0, C_FLUSH,  S_RUN,     3'b010));
        tbl.push_back(mk("frz1",    0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, C_FREEZE, S_MEMWAIT, 3'b001));
        tbl.push_back(mk("frz2",    0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, C_FREEZE, S_MEMWAIT, 3'b001));
        tbl.push_back(mk("frz3",    0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, C_FREEZE, S_MEMWAIT, 3'b001));
        tbl.push_back(mk("fl_late", 0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_FLUSH,  S_RUN,     3'b010));
        tbl.push_back(mk("norm2",   0, 1, 5'd3, 5'd4, 1, 1, 5'd9, 1, 0, 0, C_NORM,   S_RUN,     3'b000));
        tbl.push_back(mk("stop",    0, 0, 5'd5, 5'd7, 1, 1, 5'd5, 1, 1, 0, C_IDLE,   S_IDLE,    3'b000));
        tbl.push_back(mk("restart", 0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_IDLE,   S_RUN,     3'b000));
        tbl.push_back(mk("stop2",   0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, C_IDLE,   S_IDLE,    3'b000));
        tbl.push_back(mk("go_bsy",  0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, C_IDLE,   S_RUN,     3'b000));
        tbl.push_back(mk("norm3",   0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_NORM,   S_RUN,     3'b000));
        tbl.push_back(mk("rst_mid", 1, 1, 5'd5, 5'd7, 1, 1, 5'd5, 1, 0, 0, C_IDLE,   S_IDLE,    3'b000));

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i]);

        // Saturation: 20 back-to-back load-use cycles; the 4-bit counter
        // must pin at 15 while the 32-bit one reaches 20.
        apply(mk("sat_go", 0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_IDLE, S_RUN, 3'b000));
        for (int k = 0; k < 20; k++) begin
            apply(mk("sat_lu", 0, 1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, C_STALL, S_RUN, 3'b100));
        end
        check("sat_final4",  longint'(bus4.stall_cnt_o), 64'd15);
        check("sat_final32", longint'(bus32.stall_cnt_o), 64'd20);

        // Reset during a busy run clears every counter in one edge.
        apply(mk("rst_end", 1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, C_IDLE, S_IDLE, 3'b000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
`default_nettype wire
